vc_out_arbiter: RTL and testbench
=================================

VC_OUT_ARBITER -- requirements
Module: vc_out_arbiter

Interface
REQ-001 Parameter: CREDIT_MAX, default 4, downstream buffer depth in flits (range 1..15).
REQ-002 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- vc_out_0  input  8  VC0 head-of-queue flit.
- vc0_valid  input  1  VC0 flit present.
- vc0_ready  output  1  VC0 flit accepted this cycle.
- vc_out_1  input  8  VC1 head-of-queue flit.
- vc1_valid  input  1  VC1 flit present.
- vc1_ready  output  1  VC1 flit accepted this cycle.
- vc_buf_NI  input  8  NI-injected flit.
- ni_valid  input  1  NI flit present.
- ni_ready  output  1  NI flit accepted this cycle.
- credit_in  input  1  one-cycle pulse; downstream freed one slot.
- flit_out  output  8  granted flit to link.
- flit_out_valid  output  1  flit_out valid this cycle.
- grant_id  output  2  source of flit_out: 0=VC0, 1=VC1, 2=NI.
- credit_cnt  output  4  current credits.

Function
REQ-003 Flit type SHALL be flit[7:6]: 00 single, 01 head, 10 body, 11 tail.
REQ-004 The FSM SHALL have states IDLE and LOCKED.
REQ-005 In IDLE, the block SHALL grant round-robin among the valid requesters; priority starts at the source after last_grant.
REQ-006 In LOCKED, only the locked source SHALL be granted; other requesters SHALL be ignored even if valid.
REQ-007 A transfer SHALL occur when the granted source is valid and credit_cnt>0; only that source's ready SHALL be 1, combinationally, in the same cycle.
REQ-008 No ready SHALL assert while credit_cnt==0.
REQ-009 At the accepting edge, flit_out and grant_id SHALL load the transferred flit and its source, and flit_out_valid SHALL be 1 for exactly the following cycle (1-cycle latency).
REQ-010 Transitions:
- IDLE to LOCKED on a transfer of a head flit.
- LOCKED to IDLE on a transfer of a tail flit.
- A single flit SHALL leave the state IDLE.
- Body flits SHALL leave the state LOCKED.
REQ-011 last_grant SHALL update on every transfer.
REQ-012 Credit counter:
- transfer only: decrement by 1.
- credit_in only: increment by 1.
- transfer and credit_in in the same cycle: unchanged.
REQ-013 A credit_in at CREDIT_MAX without a transfer SHALL be ignored; the counter SHALL never exceed CREDIT_MAX nor drop below 0.
REQ-014 With no transfer, flit_out and grant_id SHALL hold their values and flit_out_valid SHALL be 0.
REQ-015 In IDLE, a body or tail flit from a source SHALL be transferred as a single flit and SHALL NOT lock the FSM.

Reset
REQ-016 rst_n low SHALL asynchronously set: state=IDLE, last_grant=2 (so VC0 has first priority), credit_cnt=CREDIT_MAX, flit_out=0, flit_out_valid=0, grant_id=0.
REQ-017 While rst_n is low, all ready outputs SHALL be 0.
REQ-018 A reset mid-packet SHALL abandon the lock; no partial packet SHALL resume after reset.

Configuration
REQ-019 Macro VC_OUT_ARBITER_STALL_CNT_EN.
- Defined: the block SHALL add output stall_cnt, 16 bits, reset 0, incremented each cycle any requester is valid but none is accepted, saturating at 0xFFFF.
- Undefined: the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 Reset, then vc0_valid=vc1_valid=ni_valid=1 with single flits 0x05, 0x06, 0x07 -> flit_out 0x05, 0x06, 0x07 on consecutive cycles with grant_id 0, 1, 2.
REQ-021 VC1 sends head 0x41, body 0x82, tail 0xC3 while VC0 is valid -> all three VC1 flits are sent back-to-back, then VC0 is granted.
REQ-022 CREDIT_MAX=4, continuous VC0 single flits, no credit_in -> exactly 4 flits sent, credit_cnt=0, vc0_ready=0 until credit_in, then one more flit.
REQ-023 credit_in pulse coincident with a transfer at credit_cnt=2 -> credit_cnt stays 2; credit_in at credit_cnt=4 idle -> stays 4.
REQ-024 rst_n low during LOCKED after head 0x41 -> state IDLE, credit_cnt=4, flit_out_valid=0; next grant goes to VC0.
REQ-025 With VC_OUT_ARBITER_STALL_CNT_EN defined, credits drained and VC0 valid for 10 cycles -> stall_cnt=10.

Source files
------------

// File: rtl/vc_out_arbiter.sv
// vc_out_arbiter: output-port arbiter for two virtual channels plus a
// network-interface injection source. In IDLE it arbitrates round-robin among
// the three sources. A head flit locks the link to its source until that
// source sends a tail flit. Transfers are gated by a downstream credit counter.
// The granted flit is registered, so there is one cycle of latency to flit_out.
// Optional feature: define VC_OUT_ARBITER_STALL_CNT_EN to add the stall_cnt
// output, a saturating count of cycles with a pending request and no transfer.
module vc_out_arbiter #(
    parameter int CREDIT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vc_out_0,
    input  logic        vc0_valid,
    output logic        vc0_ready,
    input  logic [7:0]  vc_out_1,
    input  logic        vc1_valid,
    output logic        vc1_ready,
    input  logic [7:0]  vc_buf_NI,
    input  logic        ni_valid,
    output logic        ni_ready,
    input  logic        credit_in,
    output logic [7:0]  flit_out,
    output logic        flit_out_valid,
    output logic [1:0]  grant_id,
`ifdef VC_OUT_ARBITER_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic [3:0]  credit_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b11;
    localparam logic [3:0] CMAX      = 4'(CREDIT_MAX);

    logic [0:0] r_state;
    // Source of the most recent transfer; while LOCKED it is also the owner.
    logic [1:0] r_last_grant;
    logic [3:0] r_credit;
    logic [7:0] r_flit_out;
    logic       r_flit_valid;
    logic [1:0] r_grant_id;

    // Four entries so any 2-bit index is in range; entry 3 is never valid.
    logic [3:0] w_valid;
    logic [7:0] w_data [4];
    logic [2:0] w_ready;
    logic [1:0] w_rank0;
    logic [1:0] w_rank1;
    logic [1:0] w_gnt;
    logic       w_gnt_valid;
    logic       w_xfer;
    logic [7:0] w_flit;
    logic [1:0] w_type;

    assign w_valid   = {1'b0, ni_valid, vc1_valid, vc0_valid};
    assign w_data[0] = vc_out_0;
    assign w_data[1] = vc_out_1;
    assign w_data[2] = vc_buf_NI;
    assign w_data[3] = 8'h00;

    // Round-robin order starts at the source after the last grant.
    assign w_rank0 = (r_last_grant >= 2'd2) ? 2'd0 : r_last_grant + 2'd1;
    assign w_rank1 = (w_rank0 == 2'd2) ? 2'd0 : w_rank0 + 2'd1;

    // Select the candidate source: the lock owner, or the first valid in RR order.
    always_comb begin
        w_gnt       = r_last_grant;
        w_gnt_valid = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_gnt_valid = w_valid[r_last_grant];
        end else if (w_valid[w_rank0]) begin
            w_gnt       = w_rank0;
            w_gnt_valid = 1'b1;
        end else if (w_valid[w_rank1]) begin
            w_gnt       = w_rank1;
            w_gnt_valid = 1'b1;
        end else if (w_valid[r_last_grant]) begin
            w_gnt_valid = 1'b1;
        end
    end

    assign w_xfer = w_gnt_valid && (r_credit != 4'd0);
    assign w_flit = w_data[w_gnt];
    assign w_type = w_flit[7:6];

    // Ready goes only to the granted source; forced low while reset is held.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ready
            assign w_ready[gi] = rst_n && w_xfer && (w_gnt == 2'(gi));
        end
    endgenerate

    assign vc0_ready = w_ready[0];
    assign vc1_ready = w_ready[1];
    assign ni_ready  = w_ready[2];

    // Packet lock FSM and round-robin pointer; reset drops any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 2'd2;
        end else if (w_xfer) begin
            r_last_grant <= w_gnt;
            if (r_state == ST_IDLE && w_type == FT_HEAD) begin
                r_state <= ST_LOCKED;
            end else if (r_state == ST_LOCKED && w_type == FT_TAIL) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Credit counter: a transfer consumes one, credit_in returns one, both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= CMAX;
        end else if (w_xfer && !credit_in) begin
            r_credit <= r_credit - 4'd1;
        end else if (!w_xfer && credit_in && r_credit < CMAX) begin
            r_credit <= r_credit + 4'd1;
        end
    end

    // Output register: load on transfer, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_out   <= 8'h00;
            r_grant_id   <= 2'd0;
            r_flit_valid <= 1'b0;
        end else begin
            r_flit_valid <= w_xfer;
            if (w_xfer) begin
                r_flit_out <= w_flit;
                r_grant_id <= w_gnt;
            end
        end
    end

    assign flit_out       = r_flit_out;
    assign flit_out_valid = r_flit_valid;
    assign grant_id       = r_grant_id;
    assign credit_cnt     = r_credit;

`ifdef VC_OUT_ARBITER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_any_valid;

    assign w_any_valid = |w_valid[2:0];

    // Saturating count of cycles where someone requested but nothing moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_any_valid && !w_xfer && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Scoreboard bench for vc_out_arbiter: per-source flit queues feed a driver
// that honours ready; tests push expected {grant_id, flit} pairs and a monitor
// compares them whenever flit_out_valid is seen.
module tb_vc_out_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic        r0, r1, r2;
    logic        credit_in = 1'b0;
    logic [7:0]  flit_out;
    logic        fov;
    logic [1:0]  gid;
    logic [3:0]  ccnt;
`ifdef VC_OUT_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0]  q0[$], q1[$], q2[$];
    logic [9:0]  exp_q[$];
    logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    vc_out_arbiter #(.CREDIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .vc_out_0(d0), .vc0_valid(v0), .vc0_ready(r0),
        .vc_out_1(d1), .vc1_valid(v1), .vc1_ready(r1),
        .vc_buf_NI(d2), .ni_valid(v2), .ni_ready(r2),
        .credit_in(credit_in),
        .flit_out(flit_out), .flit_out_valid(fov), .grant_id(gid),
`ifdef VC_OUT_ARBITER_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .credit_cnt(ccnt)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Sample ready mid-cycle.
    initial forever begin
        @(negedge clk);
        s0 = r0; s1 = r1; s2 = r2;
    end

    // Driver: retire the accepted flit after each edge and present the next one.
    initial forever begin
        @(posedge clk);
        #1;
        if (s0 && q0.size() != 0) void'(q0.pop_front());
        if (s1 && q1.size() != 0) void'(q1.pop_front());
        if (s2 && q2.size() != 0) void'(q2.pop_front());
        v0 = (q0.size() != 0); d0 = v0 ? q0[0] : 8'h00;
        v1 = (q1.size() != 0); d1 = v1 ? q1[0] : 8'h00;
        v2 = (q2.size() != 0); d2 = v2 ? q2[0] : 8'h00;
    end

    // Monitor: every valid output must match the next expected entry.
    initial forever begin
        logic [9:0] e;
        @(negedge clk);
        if (rst_n && fov) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got gid=%0d flit=%h expected none", gid, flit_out);
            end else begin
                e = exp_q.pop_front();
                if ({gid, flit_out} !== e) begin
                    n_errors++;
                    $display("FAIL out: got gid=%0d flit=%h expected gid=%0d flit=%h",
                             gid, flit_out, e[9:8], e[7:0]);
                end else begin
                    $display("ok   out: gid=%0d flit=%h", gid, flit_out);
                end
            end
        end
    end

    task automatic expect_out(input logic [1:0] g, input logic [7:0] f);
        exp_q.push_back({g, f});
    endtask

    // Hold credit_in high for n consecutive edges.
    task automatic credits(input int n);
        @(posedge clk); #1 credit_in = 1'b1;
        repeat (n) @(posedge clk);
        #1 credit_in = 1'b0;
    endtask

    // Wait (bounded) until all sources are empty and every expected output seen.
    task automatic drain();
        int k = 0;
        while ((q0.size() + q1.size() + q2.size() + exp_q.size()) != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain_done", 16'(k < 200), 16'd1);
        #2;
    endtask

    initial begin
        // Reset state, with all three sources already requesting.
        q0.push_back(8'h05); q1.push_back(8'h06); q2.push_back(8'h07);
        repeat (2) @(negedge clk);
        check("rst_ready", {13'd0, r0, r1, r2}, 16'd0);
        check("rst_valid", {15'd0, fov}, 16'd0);
        check("rst_credit", {12'd0, ccnt}, 16'd4);
        check("rst_gid", {14'd0, gid}, 16'd0);
        check("rst_flit", {8'd0, flit_out}, 16'd0);

        // Round-robin across three single flits.
        expect_out(2'd0, 8'h05); expect_out(2'd1, 8'h06); expect_out(2'd2, 8'h07);
        @(posedge clk); #3 rst_n = 1'b1;
        drain();
        check("credit_after_rr", {12'd0, ccnt}, 16'd1);
        credits(3);
        #2 check("credit_refill", {12'd0, ccnt}, 16'd4);
        credits(1);
        #2 check("credit_sat", {12'd0, ccnt}, 16'd4);

        // Locked packet on VC1 blocks VC0 until the tail.
        @(posedge clk);
        q1.push_back(8'h41); q1.push_back(8'h82); q1.push_back(8'hC3);
        expect_out(2'd1, 8'h41); expect_out(2'd1, 8'h82); expect_out(2'd1, 8'hC3);
        expect_out(2'd0, 8'h11);
        @(posedge clk);
        q0.push_back(8'h11);
        drain();
        check("credit_after_pkt", {12'd0, ccnt}, 16'd0);
        credits(4);

        // Credit exhaustion: four go, the fifth waits for credit_in.
        @(posedge clk);
        for (int i = 1; i <= 5; i++) q0.push_back(8'(i));
        for (int i = 1; i <= 4; i++) expect_out(2'd0, 8'(i));
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("credit_empty", {12'd0, ccnt}, 16'd0);
        check("stalled_v0_r0", {14'd0, v0, r0}, 16'b10);
        expect_out(2'd0, 8'h05);
        credits(1);
        drain();
        check("credit_after_one", {12'd0, ccnt}, 16'd0);
        credits(4);

        // Transfer and credit_in in the same cycle cancel.
        @(posedge clk);
        q0.push_back(8'h21); q0.push_back(8'h22);
        expect_out(2'd0, 8'h21); expect_out(2'd0, 8'h22);
        drain();
        check("credit_two", {12'd0, ccnt}, 16'd2);
        @(posedge clk);
        q0.push_back(8'h23);
        expect_out(2'd0, 8'h23);
        #1 credit_in = 1'b1;
        @(posedge clk);
        #1 credit_in = 1'b0;
        drain();
        check("credit_cancel", {12'd0, ccnt}, 16'd2);
        credits(2);

        // Reset in the middle of a locked VC1 packet.
        @(posedge clk);
        q1.push_back(8'h41);
        expect_out(2'd1, 8'h41);
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {15'd0, fov}, 16'd0);
        check("midrst_credit", {12'd0, ccnt}, 16'd4);
        check("midrst_ready", {13'd0, r0, r1, r2}, 16'd0);
        q1.push_back(8'h82); q0.push_back(8'h31);
        expect_out(2'd0, 8'h31); expect_out(2'd1, 8'h82);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        drain();
        credits(2);

`ifdef VC_OUT_ARBITER_STALL_CNT_EN
        // Stall counter: drain credits, then hold VC0 valid for ten cycles.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("stall_rst", stall_cnt, 16'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'h51 + 8'(i));
            expect_out(2'd0, 8'h51 + 8'(i));
        end
        drain();
        check("stall_none", stall_cnt, 16'd0);
        @(posedge clk);
        q0.push_back(8'h55);
        expect_out(2'd0, 8'h55);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_ten", stall_cnt, 16'd10);
        credits(1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
